// File: rtl/gpio_pkg.sv
// Shared constants, state/mode encodings and small helpers for the GPIO scan master.
package gpio_pkg;

  localparam int ADDR_W = 9;

  localparam logic [ADDR_W-1:0] ADDR_BTN    = 9'd503;
  localparam logic [ADDR_W-1:0] ADDR_SW_LO  = 9'd504;
  localparam logic [ADDR_W-1:0] ADDR_SW_HI  = 9'd505;
  localparam logic [ADDR_W-1:0] ADDR_LED_LO = 9'd506;
  localparam logic [ADDR_W-1:0] ADDR_LED_HI = 9'd507;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT0 = 9'd508;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT1 = 9'd509;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT2 = 9'd510;
  localparam logic [ADDR_W-1:0] ADDR_DIGIT3 = 9'd511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_BTN,
    ST_RD_SWL,
    ST_RD_SWH,
    ST_CALC,
    ST_WR
  } state_t;

  typedef enum logic [1:0] {
    MODE_SWITCH   = 2'd0,
    MODE_COUNT    = 2'd1,
    MODE_INVERT   = 2'd2,
    MODE_RESERVED = 2'd3
  } mode_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  // Packs the four digit bytes {d3,d2,d1,d0}, each a zero-extended nibble of v.
  function automatic logic [31:0] digits_of(input logic [15:0] v);
    return {4'b0, v[15:12], 4'b0, v[11:8], 4'b0, v[7:4], 4'b0, v[3:0]};
  endfunction

endpackage

// File: rtl/gpio_scan_master_if.sv
// Bus between the scan master and the gpiomem block.
interface gpio_scan_master_if;
  import gpio_pkg::*;

  logic              rw_select;
  logic [ADDR_W-1:0] address;
  logic [7:0]        wr_data;
  logic [7:0]        rd_data;

  modport master (output rw_select, output address, output wr_data, input rd_data);
  modport slave  (input rw_select, input address, input wr_data, output rd_data);
endinterface

// File: rtl/gpio_poll_timer.sv
// Free-running poll divider; ticks once every POLL_DIV enabled clocks.
module gpio_poll_timer #(
  parameter logic [15:0] POLL_DIV = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [15:0] count;

  localparam logic [15:0] LAST = POLL_DIV - 16'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 16'd0;
    end else if (!enable) begin
      count <= 16'd0;
    end else if (count == LAST) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/gpio_scan_master.sv
// Periodically reads buttons/switches from gpiomem and writes LEDs and digits back.
module gpio_scan_master
  import gpio_pkg::*;
#(
  parameter logic [15:0] POLL_DIV = 16'd50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          mode,
  gpio_scan_master_if.master  bus,
  output logic                busy,
  output logic [3:0]          btn_event,
  output logic [15:0]         scan_count
);

  state_t          state;
  logic [2:0]      wr_index;
  logic [2:0]      next_index;
  logic [3:0]      btn_new;
  logic [3:0]      btn_prev;
  logic [3:0]      rise;
  logic [7:0]      sw_lo;
  logic [15:0]     sw_full;
  logic [15:0]     press_count;
  logic [15:0]     press_next;
  logic [15:0]     led_val;
  logic [15:0]     digit_src;
  logic [5:0][7:0] calc_bytes;
  logic [5:0][7:0] wr_bytes;
  logic            tick;

  gpio_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // The high switch byte is on rd_data during CALC, so it feeds the byte calculation directly.
  assign sw_full    = {bus.rd_data, sw_lo};
  assign rise       = btn_new & ~btn_prev;
  assign press_next = press_count + {13'b0, popcount4(rise)};
  assign next_index = wr_index + 3'd1;
  assign busy       = (state != ST_IDLE);

  always_comb begin
    led_val   = sw_full;
    digit_src = sw_full;
    case (mode_t'(mode))
      MODE_COUNT: begin
        led_val   = scan_count;
        digit_src = scan_count;
      end
      MODE_INVERT: begin
        led_val   = ~sw_full;
        digit_src = press_next;
      end
      default: ;
    endcase
  end

  assign calc_bytes = {digits_of(digit_src), led_val};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bus.rw_select <= 1'b0;
      bus.address   <= '0;
      bus.wr_data   <= 8'd0;
      btn_event     <= 4'd0;
      scan_count    <= 16'd0;
      press_count   <= 16'd0;
      btn_prev      <= 4'd0;
      btn_new       <= 4'd0;
      sw_lo         <= 8'd0;
      wr_index      <= 3'd0;
      wr_bytes      <= '0;
    end else begin
      btn_event <= 4'd0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state       <= ST_RD_BTN;
            bus.address <= ADDR_BTN;
          end
        end
        ST_RD_BTN: begin
          state       <= ST_RD_SWL;
          bus.address <= ADDR_SW_LO;
        end
        ST_RD_SWL: begin
          btn_new     <= bus.rd_data[3:0];
          state       <= ST_RD_SWH;
          bus.address <= ADDR_SW_HI;
        end
        ST_RD_SWH: begin
          sw_lo <= bus.rd_data;
          state <= ST_CALC;
        end
        ST_CALC: begin
          wr_bytes      <= calc_bytes;
          press_count   <= press_next;
          btn_event     <= rise;
          wr_index      <= 3'd0;
          state         <= ST_WR;
          bus.rw_select <= 1'b1;
          bus.address   <= ADDR_LED_LO;
          bus.wr_data   <= calc_bytes[0];
        end
        ST_WR: begin
          if (wr_index == 3'd0) begin
            btn_prev <= btn_new;
          end
          if (wr_index == 3'd5) begin
            scan_count    <= scan_count + 16'd1;
            state         <= ST_IDLE;
            bus.rw_select <= 1'b0;
            bus.address   <= '0;
            bus.wr_data   <= 8'd0;
          end else begin
            wr_index    <= next_index;
            bus.address <= bus.address + 9'd1;
            bus.wr_data <= wr_bytes[next_index];
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.rw_select <= 1'b0;
          bus.address   <= '0;
          bus.wr_data   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_scan_master.sv
// Scoreboard bench: a gpiomem model feeds the DUT and a monitor checks every bus write and button event.
module tb_gpio_scan_master;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic        busy;
  logic [3:0]  btn_event;
  logic [15:0] scan_count;

  logic [3:0]  btn_in = 4'd0;
  logic [15:0] sw_in = 16'd0;
  logic [7:0]  mem [0:511];
  logic [8:0]  addr_q = 9'd0;
  logic [7:0]  rd_mux;

  int cycle = 0;
  int n_checks = 0;
  int n_pass = 0;

  wr_t        exp_wr[$];
  logic [3:0] exp_ev[$];

  bit spacing_en = 1'b0;
  bit skip_len = 1'b0;

  gpio_scan_master_if bus ();

  gpio_scan_master #(.POLL_DIV(16'd16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .bus        (bus),
    .busy       (busy),
    .btn_event  (btn_event),
    .scan_count (scan_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // gpiomem model: address registered on posedge, read data launched on the following negedge.
  always_comb begin
    case (addr_q)
      9'd503:  rd_mux = {4'b0, btn_in};
      9'd504:  rd_mux = sw_in[7:0];
      9'd505:  rd_mux = sw_in[15:8];
      default: rd_mux = mem[addr_q];
    endcase
  end

  always @(posedge clk) begin
    addr_q <= bus.address;
    if (bus.rw_select) mem[bus.address] <= bus.wr_data;
  end

  always @(negedge clk) bus.rd_data <= rd_mux;

  function automatic void check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endfunction

  function automatic void record_fail(input string name);
    n_checks++;
    $display("[TB] FAIL %s", name);
  endfunction

  function automatic void push_scan(input logic [15:0] leds, input logic [15:0] dig);
    exp_wr.push_back('{addr: 9'd506, data: leds[7:0]});
    exp_wr.push_back('{addr: 9'd507, data: leds[15:8]});
    exp_wr.push_back('{addr: 9'd508, data: {4'b0, dig[3:0]}});
    exp_wr.push_back('{addr: 9'd509, data: {4'b0, dig[7:4]}});
    exp_wr.push_back('{addr: 9'd510, data: {4'b0, dig[11:8]}});
    exp_wr.push_back('{addr: 9'd511, data: {4'b0, dig[15:12]}});
  endfunction

  // Monitor: pops the scoreboard on every write cycle and every button pulse, and times scans.
  initial begin
    wr_t        e;
    logic [3:0] ev;
    bit         prev_busy = 1'b0;
    bit         have_prev = 1'b0;
    int         prev_start = 0;
    int         busy_len = 0;
    forever begin
      @(negedge clk);
      if (bus.rw_select) begin
        if (bus.address >= 9'd503 && bus.address <= 9'd505)
          record_fail("write_to_input_register");
        if (exp_wr.size() == 0) begin
          record_fail("unexpected_write");
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(bus.address), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
        end
      end
      if (btn_event != 4'd0) begin
        if (exp_ev.size() == 0) begin
          record_fail("unexpected_btn_event");
        end else begin
          ev = exp_ev.pop_front();
          check("btn_event", 32'(btn_event), 32'(ev));
          check("btn_event_in_first_wr", 32'({bus.rw_select, bus.address}), 32'({1'b1, 9'd506}));
        end
      end
      if (busy) begin
        busy_len++;
        if (!prev_busy) begin
          if (spacing_en && have_prev) check("scan_spacing", 32'(cycle - prev_start), 32'd16);
          prev_start = cycle;
          have_prev  = 1'b1;
        end
      end else if (prev_busy) begin
        if (!skip_len) check("scan_length", 32'(busy_len), 32'd10);
        busy_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic apply_stimulus(input logic [15:0] sw, input logic [3:0] btn, input logic [1:0] md);
    sw_in  = sw;
    btn_in = btn;
    mode   = md;
  endtask

  task automatic check_output(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_btn_event"}, 32'(btn_event), 32'd0);
    check({tag, "_scan_count"}, 32'(scan_count), 32'd0);
    check({tag, "_rw_select"}, 32'(bus.rw_select), 32'd0);
    check({tag, "_address"}, 32'(bus.address), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  task automatic wait_scan_start(output int start_cycle);
    int t = 0;
    start_cycle = -1;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 64);
    if (!busy) record_fail("scan_start_timeout");
    else start_cycle = cycle;
  endtask

  task automatic wait_scan_end();
    int t = 0;
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) record_fail("scan_end_timeout");
  endtask

  task automatic run_scan();
    int st;
    wait_scan_start(st);
    wait_scan_end();
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int st;
    int c;
    int t;
    int busy_seen;
    reset  = 1'b0;
    enable = 1'b0;
    mode   = 2'd0;
    repeat (3) @(negedge clk);
    check_output("reset");

    // Mode 0 from reset: first scan POLL_DIV cycles after enable.
    apply_stimulus(16'hA5C3, 4'd0, 2'd0);
    push_scan(16'hA5C3, 16'hA5C3);
    reset  = 1'b1;
    enable = 1'b1;
    c = cycle;
    wait_scan_start(st);
    check("first_scan_delay", 32'(st - c), 32'd16);
    wait_scan_end();
    check("mode0_scan_count", 32'(scan_count), 32'd1);

    // Mode 1: LEDs/digits show the pre-increment scan count.
    hold_reset(3);
    apply_stimulus(16'hA5C3, 4'd0, 2'd1);
    for (int k = 0; k < 3; k++) push_scan(16'(k), 16'(k));
    reset = 1'b1;
    for (int k = 0; k < 3; k++) run_scan();
    check("mode1_scan_count", 32'(scan_count), 32'd3);

    // Button edges and mode 2.
    hold_reset(3);
    apply_stimulus(16'hA5C3, 4'b0000, 2'd0);
    push_scan(16'hA5C3, 16'hA5C3);
    reset = 1'b1;
    run_scan();
    apply_stimulus(16'hA5C3, 4'b0101, 2'd0);
    push_scan(16'hA5C3, 16'hA5C3);
    exp_ev.push_back(4'b0101);
    run_scan();
    apply_stimulus(16'hA5C3, 4'b0101, 2'd2);
    push_scan(16'h5A3C, 16'd2);
    run_scan();
    check("mode2_scan_count", 32'(scan_count), 32'd3);

    // Long run with spacing checks; counter continues from 3.
    apply_stimulus(16'hA5C3, 4'b0101, 2'd1);
    spacing_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      push_scan(16'(3 + k), 16'(3 + k));
      run_scan();
    end
    spacing_en = 1'b0;
    check("long_run_scan_count", 32'(scan_count), 32'd103);

    // Reset asserted during WR index 2 aborts the scan.
    apply_stimulus(16'h7A9B, 4'b0101, 2'd0);
    exp_wr.push_back('{addr: 9'd506, data: 8'h9B});
    exp_wr.push_back('{addr: 9'd507, data: 8'h7A});
    exp_wr.push_back('{addr: 9'd508, data: 8'h0B});
    skip_len = 1'b1;
    wait_scan_start(st);
    t = 0;
    while (!(bus.rw_select && bus.address == 9'd508) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) record_fail("wr_index2_timeout");
    reset = 1'b0;
    @(negedge clk);
    check_output("abort");
    check("abort_digit1_kept", 32'(mem[509]), 32'h06);
    check("abort_digit2_kept", 32'(mem[510]), 32'h00);
    check("abort_digit3_kept", 32'(mem[511]), 32'h00);
    repeat (2) @(negedge clk);
    skip_len = 1'b0;
    push_scan(16'h7A9B, 16'h7A9B);
    exp_ev.push_back(4'b0101);
    reset = 1'b1;
    c = cycle;
    wait_scan_start(st);
    check("resume_after_reset_delay", 32'(st - c), 32'd16);
    wait_scan_end();
    check("resume_scan_count", 32'(scan_count), 32'd1);

    // Enable dropped during RD_SWH: scan completes, no further scans.
    apply_stimulus(16'hBEEF, 4'b0101, 2'd0);
    push_scan(16'hBEEF, 16'hBEEF);
    wait_scan_start(st);
    t = 0;
    while (bus.address != 9'd505 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) record_fail("rd_swh_timeout");
    enable = 1'b0;
    wait_scan_end();
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("busy_after_disable", 32'(busy_seen), 32'd0);
    check("disable_scan_count", 32'(scan_count), 32'd2);
    check("disable_leds_lo", 32'(mem[506]), 32'hEF);
    check("disable_leds_hi", 32'(mem[507]), 32'hBE);

    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_events", 32'(exp_ev.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
